// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell walks the operands LSB-first with a
// registered carry, producing a WIDTH-bit sum and carry-out after WIDTH cycles.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] shift_a, shift_b, sum_sh;
    logic             carry;
    logic [CW-1:0]    count;

    logic load, step, finish;
    logic s, co;

    // Handshake: start is sampled only in IDLE; busy marks RUN; done is a
    // one-cycle pulse after which sum/c_out hold the completed result.
    assign s    = shift_a[0] ^ shift_b[0] ^ carry;
    assign co   = (shift_a[0] & shift_b[0]) | (shift_a[0] & carry) | (shift_b[0] & carry);
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count == LAST) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_a <= '0;
            shift_b <= '0;
            sum_sh  <= '0;
            carry   <= 1'b0;
            count   <= '0;
            sum     <= '0;
            c_out   <= 1'b0;
        end else if (load) begin
            shift_a <= a;
            shift_b <= b;
            carry   <= c_in;
            count   <= '0;
        end else if (step) begin
            shift_a <= shift_a >> 1;
            shift_b <= shift_b >> 1;
            sum_sh  <= {s, sum_sh[WIDTH-1:1]};
            carry   <= co;
            count   <= count + 1'b1;
            // Result registers move only here so they hold steady otherwise.
            if (finish) begin
                sum   <= {s, sum_sh[WIDTH-1:1]};
                c_out <= co;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: vector table plus multi-cycle sequences
// for operand isolation, mid-run reset and back-to-back starts.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       c_in = 1'b0;
    logic       busy, done, c_out;
    logic [7:0] sum;

    int tests = 0;
    int fails = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
        .busy(busy), .done(done), .sum(sum), .c_out(c_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vc;
        logic [7:0] es;
        logic       ec;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic do_add(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                          input logic [7:0] es, input logic ec, input string nm);
        int  busy_cnt;
        bit  got_done;
        busy_cnt = 0;
        got_done = 0;
        @(negedge clk);
        a = va; b = vb; c_in = vc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && !got_done; i++) begin
            if (busy) busy_cnt++;
            if (done) got_done = 1;
            else @(negedge clk);
        end
        check({nm, " done"}, 32'(got_done), 32'd1);
        check({nm, " busy_cycles"}, 32'(busy_cnt), 32'd8);
        check({nm, " sum"}, 32'(sum), 32'(es));
        check({nm, " c_out"}, 32'(c_out), 32'(ec));
        @(negedge clk);
        check({nm, " done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n_done;
        int last_done;

        vecs[0] = '{8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

        // Reset held with start asserted
        start = 1'b1; a = 8'h5A; b = 8'hC3; c_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst busy", 32'(busy), 32'd0);
            check("rst done", 32'(done), 32'd0);
            check("rst sum", 32'(sum), 32'd0);
            check("rst c_out", 32'(c_out), 32'd0);
        end
        start = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            do_add(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].es, vecs[i].ec,
                   $sformatf("vec%0d", i));

        // Operand and start isolation; prior sum is 8'hFF from the last vector
        @(negedge clk);
        a = 8'h12; b = 8'h34; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 1) begin a = 8'hFF; b = 8'hFF; c_in = 1'b1; start = 1'b1; end
            if (i == 2) start = 1'b0;
            if (busy) check("iso sum_hold", 32'(sum), 32'hFF);
            if (done) begin
                n_done++;
                check("iso sum", 32'(sum), 32'h46);
                check("iso c_out", 32'(c_out), 32'd0);
            end
            @(negedge clk);
        end
        check("iso done_count", 32'(n_done), 32'd1);

        // Reset four cycles into RUN
        a = 8'hFF; b = 8'hFF; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("midrst busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst sum", 32'(sum), 32'd0);
        check("midrst c_out", 32'(c_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("midrst no_done", 32'(n_done), 32'd0);
        do_add(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "after_rst");

        // Back-to-back with start held high
        @(negedge clk);
        a = 8'h80; b = 8'h80; c_in = 1'b1; start = 1'b1;
        n_done = 0;
        last_done = -100;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == last_done + 1) check("b2b idle_after_done", 32'(busy), 32'd0);
            if (cyc == last_done + 2) check("b2b reaccept", 32'(busy), 32'd1);
            if (done) begin
                if (n_done > 0) check("b2b period", 32'(cyc - last_done), 32'd10);
                check("b2b sum", 32'(sum), 32'h01);
                check("b2b c_out", 32'(c_out), 32'd1);
                n_done++;
                last_done = cyc;
            end
        end
        check("b2b done_count", 32'(n_done), 32'd4);
        start = 1'b0;
        for (int i = 0; i < 12; i++) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
